// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised integer register file with two combinational
// read ports, two write ports (port B wins on an address collision), an
// optional hard-wired zero register and a sequenced clear engine.
// All state updates on the falling edge of CLK; MasterReset_L is an
// asynchronous active-low reset.
// Optional feature macro: REGFILE_BYPASS_EN -- forwards in-flight write data
// to the read ports combinationally while the file is idle.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              MasterReset_L,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] writeReg2,
    input  logic [DATA_W-1:0] writeData2,
    input  logic              RegWrite2,
    input  logic              ClearReq,
    output logic              ClearBusy,
    output logic              ClearDone,
    output logic              WriteConflict
);

    localparam int DEPTH = 2**ADDR_W;
    // Index is one bit wider than an address so the terminal compare is unambiguous.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, CLEARING, DONE} state_t;

    state_t            state, state_next;
    logic [ADDR_W:0]   idx, idx_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              conflict;
    logic              wr_a, wr_b;

    // A write is effective only if enabled and not aimed at a hard-wired zero entry.
    assign wr_a = RegWrite  && !((ZERO_REG != 0) && (writeReg  == '0));
    assign wr_b = RegWrite2 && !((ZERO_REG != 0) && (writeReg2 == '0));

    assign ClearBusy     = (state == CLEARING);
    assign ClearDone     = (state == DONE);
    assign WriteConflict = conflict;

    // Clear FSM state and sweep index register.
    always_ff @(negedge CLK or negedge MasterReset_L) begin
        if (!MasterReset_L) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Clear FSM next-state: sweep every entry once, then hold DONE for one cycle.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (ClearReq) begin
                    state_next = CLEARING;
                    idx_next   = '0;
                end
            end
            CLEARING: begin
                idx_next = idx + (ADDR_W+1)'(1);
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
                idx_next   = '0;
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // Storage update: normal writes in IDLE (port B last so it wins), sweep-clear in CLEARING.
    always_ff @(negedge CLK or negedge MasterReset_L) begin
        if (!MasterReset_L) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            conflict <= 1'b0;
        end else begin
            conflict <= 1'b0;
            if (state == IDLE) begin
                if (wr_a) begin
                    mem[writeReg] <= writeData;
                end
                if (wr_b) begin
                    mem[writeReg2] <= writeData2;
                end
                conflict <= wr_a && wr_b && (writeReg == writeReg2);
            end else if (state == CLEARING) begin
                mem[idx[ADDR_W-1:0]] <= '0;
            end
        end
    end

    // Read port 1: stored value, optionally forwarded write data, zero register masked last.
    always_comb begin
        readData1 = mem[readReg1];
`ifdef REGFILE_BYPASS_EN
        if (state == IDLE) begin
            if (wr_a && (writeReg == readReg1)) begin
                readData1 = writeData;
            end
            if (wr_b && (writeReg2 == readReg1)) begin
                readData1 = writeData2;
            end
        end
`else
`endif
        if ((ZERO_REG != 0) && (readReg1 == '0)) begin
            readData1 = '0;
        end
    end

    // Read port 2: same structure as read port 1.
    always_comb begin
        readData2 = mem[readReg2];
`ifdef REGFILE_BYPASS_EN
        if (state == IDLE) begin
            if (wr_a && (writeReg == readReg2)) begin
                readData2 = writeData;
            end
            if (wr_b && (writeReg2 == readReg2)) begin
                readData2 = writeData2;
            end
        end
`else
`endif
        if ((ZERO_REG != 0) && (readReg2 == '0)) begin
            readData2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed stimulus for regfile_multiport. The stimulus
// process drives inputs just after each falling edge and queues the values it
// requires; a monitor process checks them at the following rising edge.
module tb_regfile_multiport;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int K_RD1  = 0;
    localparam int K_RD2  = 1;
    localparam int K_BUSY = 2;
    localparam int K_DONE = 3;
    localparam int K_CONF = 4;

    logic        CLK = 1'b0;
    logic        MasterReset_L = 1'b1;
    logic [4:0]  readReg1 = '0, readReg2 = '0;
    logic [31:0] readData1, readData2;
    logic [4:0]  writeReg = '0, writeReg2 = '0;
    logic [31:0] writeData = '0, writeData2 = '0;
    logic        RegWrite = 1'b0, RegWrite2 = 1'b0;
    logic        ClearReq = 1'b0;
    logic        ClearBusy, ClearDone, WriteConflict;

    typedef struct {
        int          kind;
        logic [31:0] value;
        string       name;
    } item_t;

    item_t q[$];
    int checks = 0;
    int failures = 0;

    regfile_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .CLK(CLK), .MasterReset_L(MasterReset_L),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .writeReg(writeReg), .writeData(writeData), .RegWrite(RegWrite),
        .writeReg2(writeReg2), .writeData2(writeData2), .RegWrite2(RegWrite2),
        .ClearReq(ClearReq), .ClearBusy(ClearBusy), .ClearDone(ClearDone),
        .WriteConflict(WriteConflict)
    );

    always #5 CLK = ~CLK;

    // Queue one required value for the coming rising-edge sample.
    task automatic want(input int kind, input logic [31:0] value, input string name);
        item_t it;
        it.kind = kind;
        it.value = value;
        it.name = name;
        q.push_back(it);
    endtask

    // Advance to just after the next commit edge.
    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    // Monitor: at each rising edge compare every queued requirement with the DUT.
    initial begin
        item_t it;
        logic [31:0] act;
        forever begin
            @(posedge CLK);
            while (q.size() > 0) begin
                it = q.pop_front();
                case (it.kind)
                    K_RD1:   act = readData1;
                    K_RD2:   act = readData2;
                    K_BUSY:  act = {31'd0, ClearBusy};
                    K_DONE:  act = {31'd0, ClearDone};
                    default: act = {31'd0, WriteConflict};
                endcase
                checks++;
                if (act !== it.value) begin
                    failures++;
                    $display("FAIL %s: got %h expected %h at %0t", it.name, act, it.value, $time);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, sampled while reset is held.
        #1 MasterReset_L = 1'b0;
        readReg1 = 5'd0;
        readReg2 = 5'd31;
        want(K_BUSY, 0, "reset_busy");
        want(K_DONE, 0, "reset_done");
        want(K_CONF, 0, "reset_conflict");
        want(K_RD1, 0, "reset_rd1");
        want(K_RD2, 0, "reset_rd2");
        #11 MasterReset_L = 1'b1;

        // Every entry reads zero after reset.
        for (int a = 0; a < 32; a++) begin
            cyc();
            readReg1 = 5'(a);
            readReg2 = 5'(31 - a);
            want(K_RD1, 0, "reset_sweep_rd1");
            want(K_RD2, 0, "reset_sweep_rd2");
        end

        // Port A write to reg 3.
        cyc();
        RegWrite = 1; writeReg = 5'd3; writeData = 32'hDEAD_BEEF; readReg1 = 5'd3;
        want(K_RD1, BYP ? 32'hDEAD_BEEF : 32'h0, "wr3_before_commit");
        cyc();
        RegWrite = 0;
        want(K_RD1, 32'hDEAD_BEEF, "wr3_after_commit");

        // Writes to the zero register are dropped and never conflict.
        cyc();
        RegWrite = 1; writeReg = 5'd0; writeData = 32'd5;
        RegWrite2 = 1; writeReg2 = 5'd0; writeData2 = 32'd6;
        readReg1 = 5'd0;
        want(K_RD1, 0, "zero_reg_pre");
        cyc();
        RegWrite = 0; RegWrite2 = 0;
        want(K_RD1, 0, "zero_reg_post");
        want(K_CONF, 0, "zero_reg_no_conflict");

        // Same-address collision: port B wins, conflict pulses one cycle.
        cyc();
        RegWrite = 1; writeReg = 5'd7; writeData = 32'd11;
        RegWrite2 = 1; writeReg2 = 5'd7; writeData2 = 32'd22;
        readReg1 = 5'd7;
        want(K_CONF, 0, "collide_conflict_pre");
        want(K_RD1, BYP ? 32'd22 : 32'd0, "collide_rd_pre");
        cyc();
        writeReg = 5'd8; writeData = 32'h88;
        writeReg2 = 5'd9; writeData2 = 32'h99;
        want(K_RD1, 32'd22, "collide_b_wins");
        want(K_CONF, 1, "collide_conflict_set");
        cyc();
        RegWrite = 0; RegWrite2 = 0;
        readReg1 = 5'd8; readReg2 = 5'd9;
        want(K_RD1, 32'h88, "dual_write_a");
        want(K_RD2, 32'h99, "dual_write_b");
        want(K_CONF, 0, "dual_write_no_conflict");

        // Fill regs 1..31 with their index.
        for (int i = 1; i < 32; i++) begin
            cyc();
            RegWrite = 1; writeReg = 5'(i); writeData = 32'(i);
        end
        cyc();
        RegWrite = 0;
        readReg1 = 5'd17; readReg2 = 5'd31;
        want(K_RD1, 32'd17, "fill_r17");
        want(K_RD2, 32'd31, "fill_r31");

        // Clear request; a write on the request edge is still performed.
        cyc();
        ClearReq = 1;
        RegWrite = 1; writeReg = 5'd10; writeData = 32'h1234;
        want(K_BUSY, 0, "clear_req_busy_pre");
        readReg1 = 5'd4; readReg2 = 5'd10;
        for (int c = 0; c < 32; c++) begin
            cyc();
            ClearReq = (c == 10);
            RegWrite = 1; writeReg = 5'd4; writeData = 32'd99;
            RegWrite2 = 1; writeReg2 = 5'd4; writeData2 = 32'd99;
            want(K_BUSY, 1, "clearing_busy");
            want(K_DONE, 0, "clearing_done");
            want(K_CONF, 0, "clearing_conflict");
            want(K_RD1, (c < 5) ? 32'd4 : 32'd0, "clearing_r4");
            want(K_RD2, (c < 11) ? 32'h1234 : 32'd0, "clearing_r10");
        end
        cyc();
        ClearReq = 0;
        want(K_BUSY, 0, "done_busy");
        want(K_DONE, 1, "done_pulse");
        want(K_RD1, 0, "done_r4");
        cyc();
        RegWrite = 0; RegWrite2 = 0;
        want(K_DONE, 0, "after_done");
        want(K_BUSY, 0, "after_done_busy");
        want(K_RD1, 0, "after_done_r4");
        for (int a = 0; a < 16; a++) begin
            cyc();
            readReg1 = 5'(a);
            readReg2 = 5'(a + 16);
            want(K_RD1, 0, "cleared_lo");
            want(K_RD2, 0, "cleared_hi");
        end

        // Reset in the middle of a clear.
        cyc();
        RegWrite = 1; writeReg = 5'd20; writeData = 32'h20;
        cyc();
        RegWrite = 0;
        ClearReq = 1;
        cyc();
        ClearReq = 0;
        for (int c = 0; c < 10; c++) begin
            cyc();
            want(K_BUSY, 1, "preabort_busy");
        end
        cyc();
        #2 MasterReset_L = 1'b0;
        readReg1 = 5'd20; readReg2 = 5'd6;
        want(K_BUSY, 0, "abort_busy");
        want(K_DONE, 0, "abort_done");
        want(K_RD1, 0, "abort_r20");
        #3 MasterReset_L = 1'b1;
        for (int c = 0; c < 26; c++) begin
            cyc();
            want(K_BUSY, 0, "post_abort_busy");
            want(K_DONE, 0, "post_abort_no_done");
        end
        cyc();
        RegWrite = 1; writeReg = 5'd2; writeData = 32'd7;
        cyc();
        RegWrite = 0;
        readReg1 = 5'd2;
        want(K_RD1, 32'd7, "post_abort_write");

        // Port A write with read port 2 watching the same address.
        cyc();
        RegWrite = 1; writeReg = 5'd5; writeData = 32'd42; readReg2 = 5'd5;
        want(K_RD2, BYP ? 32'd42 : 32'd0, "r5_before_commit");
        cyc();
        RegWrite = 0;
        want(K_RD2, 32'd42, "r5_after_commit");

        // Both ports to reg 5: forwarding and storage favour port B.
        cyc();
        RegWrite = 1; writeReg = 5'd5; writeData = 32'd1;
        RegWrite2 = 1; writeReg2 = 5'd5; writeData2 = 32'd2;
        want(K_RD2, BYP ? 32'd2 : 32'd42, "r5_dual_pre");
        cyc();
        RegWrite = 0; RegWrite2 = 0;
        want(K_RD2, 32'd2, "r5_dual_post");
        want(K_CONF, 1, "r5_dual_conflict");
        cyc();
        want(K_CONF, 0, "r5_conflict_clears");

        // Let the monitor drain, then report.
        @(posedge CLK);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d queued items unchecked, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the CPU integer register file.
- Generalised data width and depth; optional hard-wired zero register.
- Two combinational read ports and two write ports with defined collision priority.
- Adds a sequenced clear engine, so software or the controller can wipe the file without asserting MasterReset_L. Sits between decode and writeback in the datapath.

Parameters:
- DATA_W, 32, register data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes; 0 = entry 0 is ordinary storage

Ports:
- CLK  input  1  system clock; all state updates on negedge CLK
- MasterReset_L  input  1  asynchronous active-low reset
- readReg1  input  ADDR_W  read port 1 address
- readReg2  input  ADDR_W  read port 2 address
- readData1  output  DATA_W  read port 1 data (combinational)
- readData2  output  DATA_W  read port 2 data (combinational)
- writeReg  input  ADDR_W  write port A address
- writeData  input  DATA_W  write port A data
- RegWrite  input  1  write port A enable
- writeReg2  input  ADDR_W  write port B address
- writeData2  input  DATA_W  write port B data
- RegWrite2  input  1  write port B enable
- ClearReq  input  1  request a full sequenced clear
- ClearBusy  output  1  clear in progress; writes are dropped
- ClearDone  output  1  one-cycle pulse when a clear completes
- WriteConflict  output  1  registered pulse: both ports wrote the same address last cycle

Behaviour:
- Clock and reset: one clock (CLK), sampled on its falling edge. Asynchronous active-low reset (MasterReset_L).
- Reset, asynchronous while MasterReset_L=0:
  - all DEPTH entries = 0; FSM = IDLE; clear index = 0
  - ClearBusy = 0, ClearDone = 0, WriteConflict = 0
  - takes effect immediately, including mid-clear or mid-write
- Reads: readDataN = entry[readRegN], purely combinational.
  - ZERO_REG=1 and address 0: reads 0 regardless of storage.
  - A value written at a negedge is visible on reads after that edge.
- Writes, on negedge CLK, only in state IDLE:
  - port A writes when RegWrite=1; port B writes when RegWrite2=1
  - both enabled with the same address: port B's data is stored, and WriteConflict=1 for the following cycle; otherwise WriteConflict=0
  - ZERO_REG=1: writes to address 0 are discarded and never flag a conflict
- Clear FSM, states IDLE, CLEARING, DONE:
  - IDLE, ClearReq=1 at negedge: go to CLEARING, index = 0. Writes presented on that same edge are still performed.
  - CLEARING, each negedge: entry[index] = 0, index++. When index = DEPTH-1, go to DONE. ClearBusy=1 throughout. RegWrite and RegWrite2 are ignored and no conflict is flagged.
  - DONE, one cycle: ClearDone=1, ClearBusy=0, writes still ignored. Next negedge goes to IDLE.
  - Latency: DEPTH cycles of ClearBusy, then 1 cycle of ClearDone.
  - ClearReq while CLEARING or DONE is ignored (not queued).
  - ClearReq held high continuously: restarts from IDLE on the edge after DONE.
- Index counter is ADDR_W+1 bits, so there is no wrap ambiguity at DEPTH-1.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined: in IDLE, if RegWrite or RegWrite2 is enabled with an address equal to readRegN, readDataN returns the incoming write data combinationally, same cycle, before the negedge commit.
  - Port B has priority over port A.
  - No bypass for address 0 when ZERO_REG=1.
  - No bypass while ClearBusy or ClearDone is high.
- Undefined: reads return stored contents only; new data appears after the commit edge.

Test Plan:
- Reset then read all addresses -> every readData = 0. Write port A reg 3 = 32'hDEAD_BEEF -> readData1 with readReg1=3 shows DEADBEEF after the negedge.
- ZERO_REG=1: RegWrite=1, writeReg=0, writeData=5 -> readData1(0) = 0 and WriteConflict stays 0.
- Both ports write reg 7 (A=11, B=22) -> reg7 = 22 and WriteConflict=1 for exactly one cycle. A=reg8, B=reg9 -> both stored, no conflict.
- Fill regs 1..31 with their index, pulse ClearReq, keep RegWrite=1 to reg 4 = 99 throughout -> ClearBusy high 32 cycles, ClearDone high 1 cycle, all entries 0, reg4 never 99.
- Mid-clear (cycle 10) drop MasterReset_L for 3 ns -> FSM IDLE, ClearBusy=0, no ClearDone pulse, all entries 0. Subsequent write to reg 2 = 7 succeeds.
- With REGFILE_BYPASS_EN: write reg 5 = 42 with readReg2=5 -> readData2=42 before the negedge. Without the macro: old value before the negedge, 42 after.
